tl45_wb_queue: RTL and testbench
================================

Name: tl45_wb_queue

Overview:
- Writeback-side producer for the TL45 dual-port register file: buffers completed results and drives the file's single write port (write address, write data) at one write per cycle.
- Sits between the execute/memory writeback stage and the register file.
- Provides a bypass lookup so operand fetch sees results that are still queued and not yet committed to the register file.
- Write address 0 is the register file's "no write" encoding (register 0 is never written), so the queue never emits address 0 as a real write.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2.
ADDR_W, 4, register address width.
DATA_W, 32, register data width.

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low; asserting low clears all state immediately.
i_valid  in  1  producer has a result this cycle.
i_ready  out  1  queue can accept this cycle.
i_dr  in  ADDR_W  destination register of result.
i_value  in  DATA_W  result value.
i_wr_stall  in  1  register file write port unavailable this cycle (no dequeue).
o_wr_addr  out  ADDR_W  to register file writeAdd; 0 = no write.
o_wr_data  out  DATA_W  to register file dataI.
fwd_addr1  in  ADDR_W  bypass lookup address, port 1.
fwd_addr2  in  ADDR_W  bypass lookup address, port 2.
fwd_hit1  out  1  fwd_addr1 matches a queued entry.
fwd_hit2  out  1  fwd_addr2 matches a queued entry.
fwd_data1  out  DATA_W  newest queued value for fwd_addr1.
fwd_data2  out  DATA_W  newest queued value for fwd_addr2.
o_count  out  $clog2(DEPTH)+1  number of occupied entries.
o_empty  out  1  o_count == 0.

Behaviour:
- Storage: circular buffer of DEPTH entries {addr, data}.
  - Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - o_count is a registered counter.
- Reset (reset low, asynchronous) sets:
  - pointers = 0, o_count = 0, o_empty = 1, i_ready = 1;
  - o_wr_addr = 0, o_wr_data = 0;
  - fwd_hit1/2 = 0, fwd_data1/2 = 0.
  - Entry contents are don't-care.
  - Reset asserted mid-operation discards all queued writes; none reach the register file.
- Enqueue:
  - Handshake fires when i_valid && i_ready at the rising edge.
  - i_ready = (o_count != DEPTH) and is a function of registered state only, with no combinational path from i_valid.
  - When full, i_ready = 0 even if a dequeue occurs in the same cycle (no pass-through when full).
  - A handshake with i_dr == 0 is consumed and discarded: no entry is written and o_count does not change.
- Dequeue: combinational head presentation.
  - When not empty and i_wr_stall = 0: o_wr_addr = head.addr, o_wr_data = head.data, and the head pops at the next rising edge.
  - When empty or i_wr_stall = 1: o_wr_addr = 0 and o_wr_data = 0, and no pop occurs.
  - Result accepted at edge N appears on o_wr_* during cycle N..N+1 (if the queue was empty and unstalled) and is committed to the register file at edge N+1.
  - Steady-state throughput is 1 per cycle.
- Simultaneous push and pop (non-full, non-empty): o_count unchanged; both pointers advance.
- Ordering: strict FIFO. Two queued writes to the same register commit in arrival order, and the last one wins in the register file.
- Bypass (combinational), per lookup port n:
  - fwd_hitn = 1 if fwd_addrn != 0 and any occupied entry (head included, even if it is popping this edge) has addr == fwd_addrn.
  - fwd_datan = data of the newest such entry (closest to tail); 0 when there is no hit.
  - A result in the middle of an enqueue handshake is NOT visible to bypass in the same cycle.
  - i_wr_stall does not affect bypass.
- Invariant: 0 <= o_count <= DEPTH; pointer difference modulo DEPTH equals o_count mod DEPTH.

Test Plan:
- Reset then idle: reset low 3 cycles, release, i_valid = 0 -> o_wr_addr = 0, o_wr_data = 0, i_ready = 1, o_empty = 1, o_count = 0, fwd_hit1/2 = 0.
- Single pass: push {r5, 0xDEADBEEF} at edge 1 -> during next cycle o_wr_addr = 5, o_wr_data = 0xDEADBEEF, fwd_addr1 = 5 gives hit1 = 1, data1 = 0xDEADBEEF; after edge 2 o_empty = 1, o_wr_addr = 0.
- Fill and backpressure: i_wr_stall = 1, push r1..r4 with values 0x11..0x44 -> o_count = 4, i_ready = 0; a 5th i_valid is not accepted; release stall -> o_wr_addr sequence 1, 2, 3, 4 on consecutive cycles, then 0.
- Newest-wins bypass: stall, push {r3, 0xA}, {r7, 0xB}, {r3, 0xC} -> fwd_addr1 = 3 gives data1 = 0xC; fwd_addr2 = 7 gives data2 = 0xB; fwd_addr1 = 0 gives hit1 = 0 while r0 is absent.
- R0 discard and wrap: push {r0, 0x99} -> accepted, o_count unchanged, never appears on o_wr_addr; then stream 10 pushes with concurrent pops through DEPTH = 4 -> order preserved across pointer wrap, o_count stays at 1.
- Async reset mid-operation: 3 entries queued with stall, assert reset low between clock edges -> o_count = 0, o_wr_addr = 0, fwd_hit1/2 = 0 immediately; after release no stale writes are emitted.

Source files
------------

// File: rtl/tl45_wb_queue_if.sv
// Writeback queue bus bundle: result enqueue, register-file write port and the
// two bypass lookup ports. The queue uses the slave modport.
interface tl45_wb_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              i_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] i_dr;
  logic [DATA_W-1:0] i_value;
  logic              i_wr_stall;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic [ADDR_W-1:0] fwd_addr1;
  logic [ADDR_W-1:0] fwd_addr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
  logic [CNT_W-1:0]  o_count;
  logic              o_empty;

  modport slave (
    input  i_valid, i_dr, i_value, i_wr_stall, fwd_addr1, fwd_addr2,
    output i_ready, o_wr_addr, o_wr_data, fwd_hit1, fwd_hit2,
           fwd_data1, fwd_data2, o_count, o_empty
  );

  modport master (
    output i_valid, i_dr, i_value, i_wr_stall, fwd_addr1, fwd_addr2,
    input  i_ready, o_wr_addr, o_wr_data, fwd_hit1, fwd_hit2,
           fwd_data1, fwd_data2, o_count, o_empty
  );
endinterface

// File: rtl/tl45_wb_queue.sv
// TL45 writeback queue: buffers completed results, drives the register file's
// single write port one entry per cycle, and offers bypass of queued results.
module tl45_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  tl45_wb_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // Writes to r0 are consumed by the handshake but never stored.
  assign push  = bus.i_valid && !full && (bus.i_dr != '0);
  assign pop   = !empty && !bus.i_wr_stall;

  assign bus.i_ready   = !full;
  assign bus.o_count   = count;
  assign bus.o_empty   = empty;
  assign bus.o_wr_addr = pop ? addr_mem[head] : '0;
  assign bus.o_wr_data = pop ? data_mem[head] : '0;
  assign bus.fwd_hit1  = hit1;
  assign bus.fwd_hit2  = hit2;
  assign bus.fwd_data1 = data1;
  assign bus.fwd_data2 = data2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= bus.i_dr;
      data_mem[tail] <= bus.i_value;
    end
  end

  // Walk oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    data1 = '0;
    data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) begin
        if ((bus.fwd_addr1 != '0) && (addr_mem[head + PTR_W'(k)] == bus.fwd_addr1)) begin
          hit1  = 1'b1;
          data1 = data_mem[head + PTR_W'(k)];
        end
        if ((bus.fwd_addr2 != '0) && (addr_mem[head + PTR_W'(k)] == bus.fwd_addr2)) begin
          hit2  = 1'b1;
          data2 = data_mem[head + PTR_W'(k)];
        end
      end
    end
  end
endmodule

// File: tb/tb_tl45_wb_queue.sv
// Bench for tl45_wb_queue: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tl45_wb_queue;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk;
  logic reset;

  tl45_wb_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  tl45_wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  ent_t model[$];
  ent_t wlog[$];
  int   checks = 0;
  int   fails  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Reference model: ordered list of pending register writes.
  bit m_pop, m_push;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model.delete();
    end else begin
      m_pop  = (model.size() != 0) && !bus.i_wr_stall;
      m_push = bus.i_valid && (model.size() != DEPTH) && (bus.i_dr != '0);
      if (m_pop) void'(model.pop_front());
      if (m_push) model.push_back({bus.i_dr, bus.i_value});
    end
  end

  // Per-cycle compare against the model, and a log of emitted writes.
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data, e_d1, e_d2;
  logic              e_h1, e_h2;
  always @(negedge clk) begin
    e_addr = '0;
    e_data = '0;
    if ((model.size() != 0) && !bus.i_wr_stall) begin
      e_addr = model[0].a;
      e_data = model[0].d;
    end
    e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
    foreach (model[j]) begin
      if (bus.fwd_addr1 != '0 && model[j].a == bus.fwd_addr1) begin e_h1 = 1'b1; e_d1 = model[j].d; end
      if (bus.fwd_addr2 != '0 && model[j].a == bus.fwd_addr2) begin e_h2 = 1'b1; e_d2 = model[j].d; end
    end
    chk("model o_wr_addr", 32'(bus.o_wr_addr), 32'(e_addr));
    chk("model o_wr_data", bus.o_wr_data, e_data);
    chk("model o_count",   32'(bus.o_count), 32'(model.size()));
    chk("model o_empty",   32'(bus.o_empty), 32'(model.size() == 0));
    chk("model i_ready",   32'(bus.i_ready), 32'(model.size() != DEPTH));
    chk("model fwd_hit1",  32'(bus.fwd_hit1), 32'(e_h1));
    chk("model fwd_data1", bus.fwd_data1, e_d1);
    chk("model fwd_hit2",  32'(bus.fwd_hit2), 32'(e_h2));
    chk("model fwd_data2", bus.fwd_data2, e_d2);
    if (reset && bus.o_wr_addr != '0) wlog.push_back({bus.o_wr_addr, bus.o_wr_data});
  end

  initial begin
    reset = 1'b1;
    bus.i_valid = 1'b0; bus.i_dr = '0; bus.i_value = '0;
    bus.i_wr_stall = 1'b0; bus.fwd_addr1 = '0; bus.fwd_addr2 = '0;
    #2 reset = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    at_neg();
    chk("idle wr_addr", 32'(bus.o_wr_addr), 32'd0);
    chk("idle wr_data", bus.o_wr_data, 32'd0);
    chk("idle ready",   32'(bus.i_ready), 32'd1);
    chk("idle empty",   32'(bus.o_empty), 32'd1);
    chk("idle count",   32'(bus.o_count), 32'd0);
    chk("idle hit1",    32'(bus.fwd_hit1), 32'd0);
    chk("idle hit2",    32'(bus.fwd_hit2), 32'd0);

    // Single pass
    tick();
    bus.i_valid = 1'b1; bus.i_dr = 4'd5; bus.i_value = 32'hDEADBEEF; bus.fwd_addr1 = 4'd5;
    tick();
    bus.i_valid = 1'b0;
    at_neg();
    chk("single wr_addr", 32'(bus.o_wr_addr), 32'd5);
    chk("single wr_data", bus.o_wr_data, 32'hDEADBEEF);
    chk("single hit1",    32'(bus.fwd_hit1), 32'd1);
    chk("single data1",   bus.fwd_data1, 32'hDEADBEEF);
    tick();
    at_neg();
    chk("single empty after", 32'(bus.o_empty), 32'd1);
    chk("single wr_addr after", 32'(bus.o_wr_addr), 32'd0);

    // Fill and backpressure
    tick();
    bus.i_wr_stall = 1'b1; bus.fwd_addr1 = '0;
    for (int i = 1; i <= 4; i++) begin
      bus.i_valid = 1'b1; bus.i_dr = ADDR_W'(i); bus.i_value = 32'(i * 'h11);
      tick();
    end
    bus.i_dr = 4'd5; bus.i_value = 32'h55;
    tick();
    bus.i_valid = 1'b0;
    at_neg();
    chk("full count", 32'(bus.o_count), 32'd4);
    chk("full ready", 32'(bus.i_ready), 32'd0);
    chk("full stalled wr_addr", 32'(bus.o_wr_addr), 32'd0);
    tick();
    bus.i_wr_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("drain wr_addr", 32'(bus.o_wr_addr), 32'(k + 1));
      chk("drain wr_data", bus.o_wr_data, 32'((k + 1) * 'h11));
      tick();
    end
    at_neg();
    chk("drain done wr_addr", 32'(bus.o_wr_addr), 32'd0);
    chk("drain done empty", 32'(bus.o_empty), 32'd1);

    // Newest-wins bypass
    tick();
    bus.i_wr_stall = 1'b1;
    bus.i_valid = 1'b1; bus.i_dr = 4'd3; bus.i_value = 32'hA; tick();
    bus.i_dr = 4'd7; bus.i_value = 32'hB; tick();
    bus.i_dr = 4'd3; bus.i_value = 32'hC; tick();
    bus.i_valid = 1'b0; bus.fwd_addr1 = 4'd3; bus.fwd_addr2 = 4'd7;
    at_neg();
    chk("bypass hit1",  32'(bus.fwd_hit1), 32'd1);
    chk("bypass data1", bus.fwd_data1, 32'hC);
    chk("bypass hit2",  32'(bus.fwd_hit2), 32'd1);
    chk("bypass data2", bus.fwd_data2, 32'hB);
    tick();
    bus.fwd_addr1 = '0;
    at_neg();
    chk("bypass r0 hit1",  32'(bus.fwd_hit1), 32'd0);
    chk("bypass r0 data1", bus.fwd_data1, 32'd0);
    tick();
    bus.i_wr_stall = 1'b0; bus.fwd_addr2 = '0;
    repeat (4) tick();
    at_neg();
    chk("bypass drained", 32'(bus.o_empty), 32'd1);

    // R0 discard and wrap
    tick();
    wlog.delete();
    bus.i_valid = 1'b1; bus.i_dr = 4'd0; bus.i_value = 32'h99;
    tick();
    bus.i_valid = 1'b0;
    at_neg();
    chk("r0 count", 32'(bus.o_count), 32'd0);
    chk("r0 wr_addr", 32'(bus.o_wr_addr), 32'd0);
    for (int i = 0; i < 10; i++) begin
      bus.i_valid = 1'b1; bus.i_dr = ADDR_W'(i + 1); bus.i_value = 32'(32'h100 + i);
      tick();
      at_neg();
      chk("stream count", 32'(bus.o_count), 32'd1);
    end
    bus.i_valid = 1'b0;
    tick();
    at_neg();
    chk("stream emitted", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) begin
      chk("stream order addr", 32'(wlog[i].a), 32'(i + 1));
      chk("stream order data", wlog[i].d, 32'(32'h100 + i));
    end

    // Async reset mid-operation
    tick();
    bus.i_wr_stall = 1'b1; bus.fwd_addr1 = 4'd4; bus.fwd_addr2 = 4'd6;
    for (int i = 1; i <= 3; i++) begin
      bus.i_valid = 1'b1; bus.i_dr = ADDR_W'(2 * i); bus.i_value = 32'(i);
      tick();
    end
    bus.i_valid = 1'b0;
    at_neg();
    chk("pre-reset count", 32'(bus.o_count), 32'd3);
    chk("pre-reset hit1", 32'(bus.fwd_hit1), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async count", 32'(bus.o_count), 32'd0);
    chk("async wr_addr", 32'(bus.o_wr_addr), 32'd0);
    chk("async hit1", 32'(bus.fwd_hit1), 32'd0);
    chk("async hit2", 32'(bus.fwd_hit2), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    bus.i_wr_stall = 1'b0;
    wlog.delete();
    repeat (4) tick();
    at_neg();
    chk("no stale writes", 32'(wlog.size()), 32'd0);
    chk("post-reset empty", 32'(bus.o_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
